time_frame_sync: RTL

Serial-to-frame synchroniser between the QPSK demodulator's recovered bit stream and the time display stage. It hunts for the frame header, collects one 40-bit time frame MSB-first, and validates the checksum and BCD-free binary time ranges. It presents each validated frame on a held 40-bit bus with a one-cycle strobe. It also reports framing errors and a lock indicator.

---
 rtl/qpsk_frame_pkg.sv | 17 +
 rtl/frame_check.sv | 16 +
 rtl/time_frame_sync.sv | 111 +++++++++++
 3 files changed

// File: rtl/qpsk_frame_pkg.sv
// qpsk_frame_pkg: shared frame geometry, time range limits and sync FSM states.
package qpsk_frame_pkg;
    localparam int FRAME_W = 40;
    localparam int PAY_W = 32;
    localparam int HDR_LSB = 32;
    localparam int HOUR_LSB = 24;
    localparam int MIN_LSB = 16;
    localparam int SEC_LSB = 8;
    localparam int CHK_LSB = 0;
    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX = 8'd59;
    localparam logic [7:0] SEC_MAX = 8'd59;
    typedef enum logic {HUNT, COLLECT} state_t;
    function automatic logic [7:0] field(input logic [FRAME_W-1:0] f, input int lsb);
        return f[lsb +: 8];
    endfunction
endpackage

// File: rtl/frame_check.sv
// frame_check: combinational checksum and time range verification of a candidate frame.
module frame_check
    import qpsk_frame_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               chk_ok,
    output logic               range_ok
);
    logic [7:0] sum;
    always_comb begin
        sum = field(frame, HDR_LSB) + field(frame, HOUR_LSB) + field(frame, MIN_LSB) + field(frame, SEC_LSB);
        chk_ok = sum == field(frame, CHK_LSB);
        range_ok = field(frame, HOUR_LSB) <= HOUR_MAX && field(frame, MIN_LSB) <= MIN_MAX
                   && field(frame, SEC_LSB) <= SEC_MAX;
    end
endmodule

// File: rtl/time_frame_sync.sv
// time_frame_sync: hunts the frame header, collects a 40-bit time frame and validates it.
module time_frame_sync
    import qpsk_frame_pkg::*;
#(
    parameter logic [7:0] HEADER = 8'hCC,
    parameter int TIMEOUT = 1000,
    parameter int LOCK_N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_i,
    input  logic               bit_valid,
    output logic [FRAME_W-1:0] dat_o,
    output logic               frame_valid,
    output logic               err_o,
    output logic               locked
);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_N + 1);
    state_t state, state_d;
    logic [7:0] win, win_d, win_sh;
    logic [PAY_W-1:0] pay, pay_d, pay_sh;
    logic [4:0] cnt, cnt_d;
    logic [IW-1:0] idle, idle_d;
    logic [GW-1:0] good, good_d;
    logic [FRAME_W-1:0] dat_d, cand;
    logic fv_d, err_d, lock_d, chk_ok, range_ok;
    assign win_sh = {win[6:0], bit_i};
    assign pay_sh = {pay[PAY_W-2:0], bit_i};
    assign cand = {HEADER, pay_sh};
    frame_check u_check (
        .frame    (cand),
        .chk_ok   (chk_ok),
        .range_ok (range_ok)
    );
    always_comb begin
        state_d = state;
        win_d = win;
        pay_d = pay;
        cnt_d = cnt;
        idle_d = '0;
        good_d = good;
        dat_d = dat_o;
        fv_d = 1'b0;
        err_d = 1'b0;
        lock_d = locked;
        if (state == HUNT) begin
            if (bit_valid) begin
                win_d = win_sh;
                if (win_sh == HEADER) begin
                    state_d = COLLECT;
                    cnt_d = '0;
                end
            end
        end else if (bit_valid) begin
            pay_d = pay_sh;
            cnt_d = cnt + 5'd1;
            if (cnt == 5'd31) begin
                state_d = HUNT;
                win_d = '0;
                if (chk_ok && range_ok) begin
                    dat_d = cand;
                    fv_d = 1'b1;
                    good_d = good == GW'(LOCK_N) ? good : good + GW'(1);
                    lock_d = good_d == GW'(LOCK_N);
                end else begin
                    err_d = 1'b1;
                    good_d = '0;
                    lock_d = 1'b0;
                end
            end
        end else begin
            idle_d = idle + IW'(1);
            // A bit on the expiring edge takes the branch above, so it always wins.
            if (idle_d == IW'(TIMEOUT)) begin
                state_d = HUNT;
                win_d = '0;
                cnt_d = '0;
                idle_d = '0;
                err_d = 1'b1;
                good_d = '0;
                lock_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
            win <= '0;
            pay <= '0;
            cnt <= '0;
            idle <= '0;
            good <= '0;
            dat_o <= '0;
            frame_valid <= 1'b0;
            err_o <= 1'b0;
            locked <= 1'b0;
        end else begin
            state <= state_d;
            win <= win_d;
            pay <= pay_d;
            cnt <= cnt_d;
            idle <= idle_d;
            good <= good_d;
            dat_o <= dat_d;
            frame_valid <= fv_d;
            err_o <= err_d;
            locked <= lock_d;
        end
    end
endmodule
